// File: rtl/histo_readout.sv
// histo_readout: scans histogram RAM bins and streams header, bin words and trailer.
// Define HISTO_RO_CLEAR_EN to clear each bin as its data is captured.
module histo_readout #(
    parameter int ADDR_W     = 12,
    parameter int RAM_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              zs,
    input  logic [2:0]        adc_id,
    input  logic [ADDR_W-1:0] start_bin,
    input  logic [ADDR_W-1:0] stop_bin,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [31:0]       ram_data,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic              ram_wren,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [2:0] {IDLE, HEADER, SCAN, DRAIN, TRAILER} state_t;
    state_t            state, state_n;
    logic              zs_r;
    logic [2:0]        adc_r;
    logic [ADDR_W-1:0] start_r, stop_r, bin;
    logic [19:0]       nwords;
    logic [RAM_LAT-1:0] vld;
    logic [ADDR_W-1:0] apipe [RAM_LAT];
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     count, outstanding;
    logic              cap, keep, push, pop, trl_xfer, issue_ok;
    logic [19:0]       sat;
    logic [31:0]       push_data;
    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RAM_LAT; i++) outstanding = outstanding + CW'(vld[i]);
    end
    // Reads in flight plus queued words never exceed the FIFO, so a returning word always fits.
    assign issue_ok  = (CW+1)'(outstanding) + (CW+1)'(count) < (CW+1)'(FIFO_DEPTH);
    assign cap       = vld[RAM_LAT-1];
    assign keep      = cap && (!zs_r || ram_data != '0);
    assign sat       = ram_data[31:20] != '0 ? 20'hFFFFF : ram_data[19:0];
    assign push      = state == HEADER || keep;
    assign push_data = state == HEADER ? {8'hA5, zs_r, adc_r, 4'h0, start_r[7:0], stop_r[7:0]}
                     : zs_r ? {12'(apipe[RAM_LAT-1]), sat} : ram_data;
    assign pop       = count != '0 && out_ready;
    assign out_valid = count != '0 || state == TRAILER;
    assign out_data  = count != '0 ? mem[rp] : state == TRAILER ? {8'h5A, 4'h0, nwords} : '0;
    assign trl_xfer  = state == TRAILER && count == '0 && out_ready;
    assign busy      = state != IDLE;
    assign ram_addr  = ram_rd ? bin : '0;
`ifdef HISTO_RO_CLEAR_EN
    assign ram_wren    = cap && !abort;
    assign ram_wr_addr = ram_wren ? apipe[RAM_LAT-1] : '0;
`else
    assign ram_wren    = 1'b0;
    assign ram_wr_addr = '0;
`endif
    always_comb begin
        state_n = state;
        ram_rd  = 1'b0;
        case (state)
            IDLE:    if (start) state_n = HEADER;
            HEADER:  state_n = stop_r < start_r ? TRAILER : SCAN;
            SCAN: begin
                ram_rd = issue_ok;
                if (issue_ok && bin == stop_r) state_n = DRAIN;
            end
            DRAIN:   if (outstanding == '0) state_n = TRAILER;
            TRAILER: if (trl_xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            ram_rd  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            zs_r    <= 1'b0;
            adc_r   <= '0;
            start_r <= '0;
            stop_r  <= '0;
            bin     <= '0;
            nwords  <= '0;
            vld     <= '0;
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            done    <= 1'b0;
            for (int i = 0; i < RAM_LAT; i++) apipe[i] <= '0;
        end else begin
            state <= state_n;
            done  <= trl_xfer && !abort;
            if (state == IDLE && start && !abort) begin
                zs_r    <= zs;
                adc_r   <= adc_id;
                start_r <= start_bin;
                stop_r  <= stop_bin;
                bin     <= start_bin;
                nwords  <= '0;
            end else if (ram_rd) begin
                bin <= bin + 1'b1;
            end
            if (keep && !abort) nwords <= nwords + 1'b1;
            vld[0]   <= ram_rd;
            apipe[0] <= bin;
            for (int i = 1; i < RAM_LAT; i++) begin
                vld[i]   <= vld[i-1];
                apipe[i] <= apipe[i-1];
            end
            if (abort) begin
                vld   <= '0;
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (push) wp <= wp == PW'(FIFO_DEPTH - 1) ? '0 : wp + 1'b1;
                if (pop) rp <= rp == PW'(FIFO_DEPTH - 1) ? '0 : rp + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_data;
    end
endmodule
